sht21_meas_sequencer: RTL and testbench

//  Upstream master for the 8-bit IIC read controller. It schedules SHT21 measurements periodically: temperature
//  (hold-master cmd 0xE3), then relative humidity (0xE5). For each measurement it drives the controller's

---
 rtl/sht21_meas_sequencer_if.sv | 32 +++
 rtl/sht21_meas_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_sht21_meas_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sht21_meas_sequencer_if.sv
// rtl/sht21_meas_sequencer_if.sv - handshake/bus bundle between the SHT21 sequencer and the IIC read controller
interface sht21_meas_sequencer_if;
  logic [7:0] iic_rdms;
  logic [7:0] iic_rdls;
  logic       iic_ack;
  logic       iic_en;
  logic [7:0] dev_wradd;
  logic [7:0] dev_rdadd;
  logic [7:0] dev_sdcmd;

  // sequencer side: issues starts and addressing, receives the result bytes
  modport master (
    input  iic_rdms,
    input  iic_rdls,
    input  iic_ack,
    output iic_en,
    output dev_wradd,
    output dev_rdadd,
    output dev_sdcmd
  );

  // controller side
  modport slave (
    output iic_rdms,
    output iic_rdls,
    output iic_ack,
    input  iic_en,
    input  dev_wradd,
    input  dev_rdadd,
    input  dev_sdcmd
  );
endinterface

// File: rtl/sht21_meas_sequencer.sv
// rtl/sht21_meas_sequencer.sv - periodic SHT21 temperature/humidity measurement scheduler for the IIC read controller
module sht21_meas_sequencer #(
  parameter int unsigned PERIOD_CYCLES  = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned GAP_CYCLES     = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  sht21_meas_sequencer_if.master       bus,
  output logic [15:0]                  temp_raw,
  output logic [15:0]                  humi_raw,
  output logic                         temp_valid,
  output logic                         humi_valid,
  output logic                         err,
  output logic [7:0]                   err_cnt,
  output logic                         busy
);

  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] PER_LAST = 32'(PERIOD_CYCLES - 1);
  localparam logic [7:0]  CMD_TEMP = 8'hE3;
  localparam logic [7:0]  CMD_HUMI = 8'hE5;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BUSY, S_CHECK, S_GAP, S_WAIT_TICK
  } state_t;

  state_t      state, next_state;
  logic        sel, sel_next;              // 0 = temperature, 1 = humidity
  logic        timed_out, timed_out_next;  // last measurement of this pair timed out
  logic [31:0] cnt, cnt_d;
  logic        ack_d;
  logic [7:0]  rdms_q;
  logic [7:1]  rdls_q;                     // bit 0 carries no information for the raw word
  logic        iic_en_q, iic_en_d;
  logic [7:0]  sdcmd_q, sdcmd_d;
  logic [15:0] temp_raw_d, humi_raw_d;
  logic        temp_valid_d, humi_valid_d, err_d, busy_d;
  logic [7:0]  err_cnt_d;

  logic        ack_edge;
  logic        timeout_hit;
  logic        gap_done;
  logic        status_ok;
  logic [15:0] word;

  assign ack_edge    = bus.iic_ack & ~ack_d;
  assign timeout_hit = (state == S_BUSY) && !ack_edge && (cnt == TO_LAST);
  // the controller must have dropped ack before it is safe to start it again
  assign gap_done    = (cnt >= GAP_LAST) && !bus.iic_ack;
  // SHT21 status bit 1 tells which measurement the word belongs to
  assign status_ok   = (rdls_q[1] == sel);
  assign word        = {rdms_q, rdls_q[7:2], 2'b00};

  assign bus.iic_en    = iic_en_q;
  assign bus.dev_sdcmd = sdcmd_q;
  assign bus.dev_wradd = 8'h80;
  assign bus.dev_rdadd = 8'h81;

  // FSM state register with measurement selector and pair-abort flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sel       <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= next_state;
      sel       <= sel_next;
      timed_out <= timed_out_next;
    end
  end

  // next-state logic
  always_comb begin
    next_state     = state;
    sel_next       = sel;
    timed_out_next = timed_out;
    case (state)
      S_IDLE: begin
        if (enable) begin
          next_state = S_START;
          sel_next   = 1'b0;
        end
      end
      S_START: begin
        next_state     = S_BUSY;
        timed_out_next = 1'b0;
      end
      S_BUSY: begin
        if (ack_edge) begin
          next_state = S_CHECK;
        end else if (cnt == TO_LAST) begin
          next_state     = S_GAP;
          timed_out_next = 1'b1;
        end
      end
      S_CHECK: next_state = S_GAP;
      S_GAP: begin
        if (gap_done) begin
          if (!enable) begin
            next_state = S_IDLE;
            sel_next   = 1'b0;
          end else if (!sel && !timed_out) begin
            next_state = S_START;
            sel_next   = 1'b1;
          end else begin
            next_state = S_WAIT_TICK;
            sel_next   = 1'b0;
          end
        end
      end
      S_WAIT_TICK: begin
        if (!enable) begin
          next_state = S_IDLE;
        end else if (cnt == PER_LAST) begin
          next_state = S_START;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // output/datapath next values; every output is registered from these
  always_comb begin
    iic_en_d     = (next_state == S_START);
    busy_d       = (next_state != S_IDLE);
    sdcmd_d      = sdcmd_q;
    // the command only moves when a new start is issued, so it is stable for the whole transfer
    if (next_state == S_START && state != S_START) begin
      sdcmd_d = sel_next ? CMD_HUMI : CMD_TEMP;
    end
    temp_valid_d = (state == S_CHECK) && !sel && status_ok;
    humi_valid_d = (state == S_CHECK) &&  sel && status_ok;
    err_d        = timeout_hit || ((state == S_CHECK) && !status_ok);
    err_cnt_d    = (err_d && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    temp_raw_d   = temp_valid_d ? word : temp_raw;
    humi_raw_d   = humi_valid_d ? word : humi_raw;
    // counter restarts on entry to START/GAP/WAIT_TICK and keeps running from START into BUSY,
    // so the timeout is measured from the start pulse itself
    if (next_state != state && next_state != S_BUSY) begin
      cnt_d = '0;
    end else if (cnt != '1) begin
      cnt_d = cnt + 32'd1;
    end else begin
      cnt_d = cnt;
    end
  end

  // registered outputs, counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      ack_d      <= 1'b0;
      rdms_q     <= '0;
      rdls_q     <= '0;
      iic_en_q   <= 1'b0;
      sdcmd_q    <= CMD_TEMP;
      temp_raw   <= '0;
      humi_raw   <= '0;
      temp_valid <= 1'b0;
      humi_valid <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      busy       <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      ack_d      <= bus.iic_ack;
      if (state == S_BUSY && ack_edge) begin
        rdms_q <= bus.iic_rdms;
        rdls_q <= bus.iic_rdls[7:1];
      end
      iic_en_q   <= iic_en_d;
      sdcmd_q    <= sdcmd_d;
      temp_raw   <= temp_raw_d;
      humi_raw   <= humi_raw_d;
      temp_valid <= temp_valid_d;
      humi_valid <= humi_valid_d;
      err        <= err_d;
      err_cnt    <= err_cnt_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_sht21_meas_sequencer.sv
// tb/tb_sht21_meas_sequencer.sv - scoreboard testbench for sht21_meas_sequencer
module tb_sht21_meas_sequencer;
  localparam int PER = 50;
  localparam int GAP = 16;
  localparam int TO  = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [15:0] temp_raw, humi_raw;
  logic temp_valid, humi_valid, err, busy;
  logic [7:0] err_cnt;

  logic sat_rst = 1'b1;
  logic [15:0] sat_temp_raw, sat_humi_raw;
  logic sat_temp_valid, sat_humi_valid, sat_err, sat_busy;
  logic [7:0] sat_err_cnt;

  sht21_meas_sequencer_if bus();
  sht21_meas_sequencer_if sat_bus();

  sht21_meas_sequencer #(.PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus),
    .temp_raw(temp_raw), .humi_raw(humi_raw), .temp_valid(temp_valid), .humi_valid(humi_valid),
    .err(err), .err_cnt(err_cnt), .busy(busy)
  );

  // short timings so 256 timeouts fit in a few thousand cycles
  sht21_meas_sequencer #(.PERIOD_CYCLES(4), .TIMEOUT_CYCLES(8), .GAP_CYCLES(4)) u_sat (
    .clk(clk), .rst(sat_rst), .enable(1'b1), .bus(sat_bus),
    .temp_raw(sat_temp_raw), .humi_raw(sat_humi_raw), .temp_valid(sat_temp_valid),
    .humi_valid(sat_humi_valid), .err(sat_err), .err_cnt(sat_err_cnt), .busy(sat_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int failed = 0;

  typedef struct {
    int          kind;   // 0 temp, 1 humi, 2 err (val = err_cnt)
    logic [15:0] val;
    int          at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [15:0] act);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      failed++;
      $display("FAIL sb_unexpected: kind %0d value %h at cycle %0d, nothing expected", kind, act, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val !== act || e.at != cyc) begin
        failed++;
        $display("FAIL sb_kind%0d: got kind %0d value %h at cycle %0d, expected kind %0d value %h at cycle %0d",
                 e.kind, kind, act, cyc, e.kind, e.val, e.at);
      end
    end
  endtask

  // monitor: every strobe from the DUT consumes one scoreboard entry
  always @(negedge clk) begin
    if (!rst) begin
      if (temp_valid) sb_pop(0, temp_raw);
      if (humi_valid) sb_pop(1, humi_raw);
      if (err)        sb_pop(2, {8'h00, err_cnt});
    end
  end

  // saturation monitor: err_cnt follows min(errors seen, 255)
  int sat_k = 0;
  always @(negedge clk) begin
    if (!sat_rst && sat_err) begin
      sat_k = sat_k + 1;
      check("sat_err_cnt", {24'h0, sat_err_cnt}, (sat_k > 255) ? 32'd255 : 32'(sat_k));
    end
  end

  task automatic wait_en(input int budget, output int n);
    n = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.iic_en) begin
        n = cyc;
        break;
      end
    end
    compared++;
    if (n < 0) begin
      failed++;
      $display("FAIL wait_en: no iic_en within %0d cycles", budget);
    end
  endtask

  // controller model: after 'dly' cycles raise ack with the result bytes, hold it 4 cycles
  task automatic reply(input logic [7:0] ms, input logic [7:0] ls, input int kind,
                       input logic [15:0] val, input int dly, output int e);
    repeat (dly) @(negedge clk);
    bus.iic_rdms = ms;
    bus.iic_rdls = ls;
    bus.iic_ack  = 1'b1;
    e = cyc;
    sb.push_back('{kind: kind, val: val, at: e + 2});
    repeat (4) @(negedge clk);
    bus.iic_ack = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_iic_en"},   {31'h0, bus.iic_en}, 32'h0);
    check({tag, "_sdcmd"},    {24'h0, bus.dev_sdcmd}, 32'hE3);
    check({tag, "_temp_raw"}, {16'h0, temp_raw}, 32'h0);
    check({tag, "_humi_raw"}, {16'h0, humi_raw}, 32'h0);
    check({tag, "_err_cnt"},  {24'h0, err_cnt}, 32'h0);
    check({tag, "_strobes"},  {29'h0, temp_valid, humi_valid, err}, 32'h0);
    check({tag, "_busy"},     {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int n, m, e, eh, cnt_en;
    bus.iic_ack = 1'b0;
    bus.iic_rdms = 8'h00;
    bus.iic_rdls = 8'h00;
    sat_bus.iic_ack = 1'b0;
    sat_bus.iic_rdms = 8'h00;
    sat_bus.iic_rdls = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    check("reset_wradd", {24'h0, bus.dev_wradd}, 32'h80);
    check("reset_rdadd", {24'h0, bus.dev_rdadd}, 32'h81);
    rst = 1'b0;
    sat_rst = 1'b0;
    enable = 1'b1;

    // T1: temperature then humidity
    wait_en(10, n);
    check("t1_cmd_temp", {24'h0, bus.dev_sdcmd}, 32'hE3);
    check("t1_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("t1_en_one_cycle", {31'h0, bus.iic_en}, 32'h0);
    reply(8'h66, 8'h7C, 0, 16'h667C, 19, e);
    wait_en(40, n);
    check("t1_humi_start_cycle", 32'(n), 32'(e + 18));
    check("t1_cmd_humi", {24'h0, bus.dev_sdcmd}, 32'hE5);
    reply(8'h7E, 8'h5A, 1, 16'h7E58, 20, eh);

    // T4: humidity ack edge to next temperature start
    wait_en(100, n);
    check("t4_ack_to_en", 32'(n - eh), 32'(1 + GAP + PER + 1));
    check("t4_cmd_temp", {24'h0, bus.dev_sdcmd}, 32'hE3);

    // T2: temperature status mismatch
    reply(8'h66, 8'h7E, 2, 16'd1, 20, e);
    wait_en(40, n);
    check("t2_humi_after_err", 32'(n), 32'(e + 18));
    check("t2_cmd_humi", {24'h0, bus.dev_sdcmd}, 32'hE5);
    check("t2_temp_held", {16'h0, temp_raw}, 32'h667C);
    reply(8'h12, 8'h36, 1, 16'h1234, 20, eh);

    // T3: timeout, humidity skipped
    wait_en(100, n);
    sb.push_back('{kind: 2, val: 16'd2, at: n + TO});
    wait_en(400, m);
    check("t3_next_start", 32'(m - n), 32'(TO + GAP + PER));
    check("t3_cmd_temp", {24'h0, bus.dev_sdcmd}, 32'hE3);

    // T5: enable dropped in BUSY
    repeat (5) @(negedge clk);
    enable = 1'b0;
    reply(8'h40, 8'h44, 0, 16'h4044, 15, e);
    repeat (13) @(negedge clk);
    check("t5_busy_in_gap", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("t5_idle_after_gap", {31'h0, busy}, 32'h0);
    cnt_en = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.iic_en) cnt_en++;
    end
    check("t5_no_start", 32'(cnt_en), 32'h0);
    check("t5_humi_kept", {16'h0, humi_raw}, 32'h1234);
    check("t5_sb_drained", 32'(sb.size()), 32'h0);

    // T6: asynchronous reset mid-BUSY
    enable = 1'b1;
    wait_en(10, n);
    repeat (10) @(negedge clk);
    check("t6_busy_before", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check_reset("t6");
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10000 && sat_k < 256; i++) @(negedge clk);
    check("sat_reached_256", {31'h0, (sat_k >= 256)}, 32'h1);
    check("sat_final", {24'h0, sat_err_cnt}, 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
